tag_verify_unit: RTL and testbench

TAG_VERIFY_UNIT -- requirements
Module: tag_verify_unit

---
 rtl/tag_verify_unit.sv | 115 +++++++++++
 tb/tb_tag_verify_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_verify_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tag_verify_unit: constant-time compare of a latched 128-bit tag with a    |
// | streamed expected tag (MSB word first).                  Revision: 1.0    |
// +--------------------------------------------------------------------------+
module tag_verify_unit #(
  parameter int WORD_W = 32
) (
  input  logic              clock_i,
  input  logic              resetb_i,
  input  logic              start_i,
  input  logic [127:0]      tag_i,
  input  logic              abort_i,
  input  logic [WORD_W-1:0] exp_word_i,
  input  logic              exp_valid_i,
  output logic              exp_ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              tag_ok_o
);

  localparam int N     = 128 / WORD_W;
  localparam int CNT_W = $clog2(N) + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [127:0]       tag_q, tag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  diff_q, diff_d;
  logic               ok_q, ok_d;
  logic               done_q, done_d;
  logic [WORD_W-1:0]  slice;

  // Constant-index mux keeps the word select free of variable part-selects.
  always_comb begin
    slice = tag_q[127 -: WORD_W];
    for (int k = 0; k < N; k++) begin
      if (cnt_q == CNT_W'(k)) slice = tag_q[127 - k*WORD_W -: WORD_W];
    end
  end

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    ok_d    = ok_q;
    done_d  = 1'b0;
    if (abort_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      diff_d  = '0;
      ok_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            tag_d   = tag_i;
            cnt_d   = '0;
            diff_d  = '0;
            ok_d    = 1'b0;
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (exp_valid_i) begin
            diff_d = diff_q | (exp_word_i ^ slice);
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N - 1)) state_d = ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          ok_d    = (diff_q == '0);
          state_d = ST_DONE;
        end
        ST_DONE: begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= ST_IDLE;
      tag_q   <= '0;
      cnt_q   <= '0;
      diff_q  <= '0;
      ok_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      ok_q    <= ok_d;
      done_q  <= done_d;
    end
  end

  assign exp_ready_o = (state_q == ST_LOAD);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign tag_ok_o    = ok_q;

endmodule
`default_nettype wire

// File: tb/tb_tag_verify_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tag_verify_unit: directed bench for 32- and 64-bit word variants.      |
// |                                                          Revision: 1.0    |
// +--------------------------------------------------------------------------+
module tb_tag_verify_unit;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start_in [2];
  logic         abort_in [2];
  logic         valid_in [2];
  logic [127:0] tag_in   [2];
  logic [63:0]  word_in  [2];
  logic         rdy      [2];
  logic         busy     [2];
  logic         done     [2];
  logic         ok       [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc [2];
  int acc_n   [2];
  int done_cyc[2];
  int done_n  [2];

  localparam logic [127:0] T = 128'h0123456789ABCDEF_FEDCBA9876543210;

  always #5 clk = ~clk;

  tag_verify_unit #(.WORD_W(32)) u_dut32 (
    .clock_i(clk), .resetb_i(rstn), .start_i(start_in[0]), .tag_i(tag_in[0]),
    .abort_i(abort_in[0]), .exp_word_i(word_in[0][31:0]), .exp_valid_i(valid_in[0]),
    .exp_ready_o(rdy[0]), .busy_o(busy[0]), .done_o(done[0]), .tag_ok_o(ok[0])
  );

  tag_verify_unit #(.WORD_W(64)) u_dut64 (
    .clock_i(clk), .resetb_i(rstn), .start_i(start_in[1]), .tag_i(tag_in[1]),
    .abort_i(abort_in[1]), .exp_word_i(word_in[1]), .exp_valid_i(valid_in[1]),
    .exp_ready_o(rdy[1]), .busy_o(busy[1]), .done_o(done[1]), .tag_ok_o(ok[1])
  );

  // Behavioural model: collects accepted words and compares the whole
  // concatenation with the captured tag once the last word has arrived.
  logic         m_active [2];
  int           m_cnt    [2];
  int           m_tail   [2];
  logic         m_ok     [2];
  logic [127:0] m_tag    [2];
  logic [127:0] m_acc    [2];

  function automatic int nwords(input int u);
    return (u == 0) ? 4 : 2;
  endfunction

  function automatic logic [127:0] word_of(input int u);
    return (u == 0) ? {96'b0, word_in[0][31:0]} : {64'b0, word_in[1]};
  endfunction

  always @(posedge clk or negedge rstn) begin
    for (int u = 0; u < 2; u++) begin
      if (!rstn) begin
        m_active[u] <= 1'b0; m_cnt[u] <= 0; m_tail[u] <= 0;
        m_ok[u] <= 1'b0; m_tag[u] <= '0; m_acc[u] <= '0;
      end else if (abort_in[u]) begin
        m_active[u] <= 1'b0; m_cnt[u] <= 0; m_tail[u] <= 0;
        m_ok[u] <= 1'b0; m_acc[u] <= '0;
      end else if (!m_active[u]) begin
        m_tail[u] <= 0;
        if (start_in[u]) begin
          m_active[u] <= 1'b1; m_tag[u] <= tag_in[u]; m_cnt[u] <= 0;
          m_acc[u] <= '0; m_ok[u] <= 1'b0;
        end
      end else if (m_cnt[u] < nwords(u)) begin
        if (valid_in[u]) begin
          m_acc[u] <= (m_acc[u] << ((u == 0) ? 32 : 64)) | word_of(u);
          m_cnt[u] <= m_cnt[u] + 1;
          if (m_cnt[u] + 1 == nwords(u)) m_tail[u] <= 1;
        end
      end else if (m_tail[u] == 1) begin
        m_ok[u]   <= (m_acc[u] == m_tag[u]);
        m_tail[u] <= 2;
      end else begin
        m_active[u] <= 1'b0;
        m_tail[u]   <= 3;
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d ready", u), 128'(rdy[u]),  128'(m_active[u] && m_cnt[u] < nwords(u)));
      chk($sformatf("u%0d busy", u),  128'(busy[u]), 128'(m_active[u]));
      chk($sformatf("u%0d done", u),  128'(done[u]), 128'(m_tail[u] == 3));
      chk($sformatf("u%0d ok", u),    128'(ok[u]),   128'(m_ok[u]));
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int u = 0; u < 2; u++) begin
      if (rstn && valid_in[u] && rdy[u] && !abort_in[u]) begin
        acc_cyc[u] <= cyc + 1;
        acc_n[u]   <= acc_n[u] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (done[u]) begin
        done_cyc[u] <= cyc;
        done_n[u]   <= done_n[u] + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int u, input logic [127:0] tag);
    start_in[u] = 1'b1; tag_in[u] = tag;
    step();
    start_in[u] = 1'b0;
  endtask

  task automatic send(input int u, input logic [63:0] w, input int gap);
    repeat (gap) step();
    valid_in[u] = 1'b1; word_in[u] = w;
    step();
    valid_in[u] = 1'b0;
  endtask

  task automatic run32(input logic [63:0] w [4], input int gapmax);
    start_run(0, T);
    for (int i = 0; i < 4; i++) send(0, w[i], (gapmax == 0) ? 0 : $urandom_range(0, gapmax));
    repeat (3) step();
  endtask

  logic [63:0] good [4];
  logic [63:0] bad  [4];
  int d0;
  int a0;

  initial begin
    good = '{64'h01234567, 64'h89ABCDEF, 64'hFEDCBA98, 64'h76543210};
    bad  = '{64'h01234566, 64'h89ABCDEF, 64'hFEDCBA98, 64'h76543210};
    for (int u = 0; u < 2; u++) begin
      start_in[u] = 0; abort_in[u] = 0; valid_in[u] = 0;
      tag_in[u] = '0; word_in[u] = '0;
      acc_cyc[u] = 0; acc_n[u] = 0; done_cyc[u] = -100; done_n[u] = 0;
    end
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", 128'(rdy[0]), 128'd0);
    chk("reset busy",  128'(busy[0]), 128'd0);
    chk("reset ok",    128'(ok[0]), 128'd0);

    // Start on the first edge after reset release.
    rstn = 1'b1;
    start_run(0, T);
    chk("first-edge start ready", 128'(rdy[0]), 128'd1);
    for (int i = 0; i < 4; i++) send(0, good[i], 0);
    repeat (3) step();
    chk("match latency", 128'(done_cyc[0] - acc_cyc[0]), 128'd2);
    chk("match ok", 128'(ok[0]), 128'd1);

    run32(bad, 0);
    chk("mismatch latency", 128'(done_cyc[0] - acc_cyc[0]), 128'd2);
    chk("mismatch ok", 128'(ok[0]), 128'd0);

    a0 = acc_n[0];
    run32(good, 5);
    chk("stall accepts", 128'(acc_n[0] - a0), 128'd4);
    chk("stall ok", 128'(ok[0]), 128'd1);

    // Abort after word 2, coinciding with a third-word handshake.
    start_run(0, T);
    send(0, good[0], 0);
    send(0, good[1], 0);
    d0 = done_n[0];
    abort_in[0] = 1'b1; valid_in[0] = 1'b1; word_in[0] = good[2];
    step();
    abort_in[0] = 1'b0; valid_in[0] = 1'b0;
    chk("abort busy", 128'(busy[0]), 128'd0);
    chk("abort ok", 128'(ok[0]), 128'd0);
    repeat (4) step();
    chk("abort no done", 128'(done_n[0] - d0), 128'd0);
    run32(good, 0);
    chk("post-abort ok", 128'(ok[0]), 128'd1);

    // Abort wins over start in IDLE.
    abort_in[0] = 1'b1; start_in[0] = 1'b1; tag_in[0] = T;
    step();
    abort_in[0] = 1'b0; start_in[0] = 1'b0;
    chk("abort+start busy", 128'(busy[0]), 128'd0);

    // Reset during COMPARE.
    start_run(0, T);
    for (int i = 0; i < 4; i++) send(0, good[i], 0);
    d0 = done_n[0];
    #2 rstn = 1'b0;
    #1;
    chk("rst busy", 128'(busy[0]), 128'd0);
    chk("rst ready", 128'(rdy[0]), 128'd0);
    chk("rst done", 128'(done[0]), 128'd0);
    chk("rst ok", 128'(ok[0]), 128'd0);
    step();
    rstn = 1'b1;
    repeat (4) step();
    chk("rst no done", 128'(done_n[0] - d0), 128'd0);

    // 64-bit words, start pulse during LOAD must not reload the tag.
    start_run(1, T);
    send(1, 64'h0123456789ABCDEF, 0);
    start_in[1] = 1'b1; tag_in[1] = ~T;
    step();
    start_in[1] = 1'b0;
    send(1, 64'hFEDCBA9876543210, 0);
    repeat (3) step();
    chk("w64 latency", 128'(done_cyc[1] - acc_cyc[1]), 128'd2);
    chk("w64 ok", 128'(ok[1]), 128'd1);

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
